alu_req_arbiter: RTL and testbench
==================================

// Module: alu_req_arbiter
// PURPOSE
//  Shares one registered alu instance between NUM_REQ requesters. Grants round-robin, drives the ALU operand/mode bus, and waits ALU_LATENCY cycles.
//  Returns the result tagged with the requester id on a valid/ready response port. One operation in flight at a time.
// PARAMETERS
//  DATA_WIDTH   8  operand/result width; must match the alu instance
//  NUM_REQ      4  number of requesters, 2..8
//  ALU_LATENCY  1  clock edges from alu_a/alu_b/alu_mode change to alu_result valid, 0..7
// PORTS
//  clk        in   1                   system clock, rising edge
//  reset_n    in   1                   asynchronous reset, active-low
//  req_valid  in   NUM_REQ             per-requester operation request
//  req_ready  out  NUM_REQ             one-hot accept; handshake when req_valid[i]&req_ready[i]
//  req_a      in   NUM_REQ*DATA_WIDTH  operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_b      in   NUM_REQ*DATA_WIDTH  operand B, same packing
//  req_mode   in   NUM_REQ*4           opcode, requester i at [i*4 +: 4]
//  alu_a      out  DATA_WIDTH          to alu in_a (registered)
//  alu_b      out  DATA_WIDTH          to alu in_b (registered)
//  alu_mode   out  4                   to alu in_mode (registered)
//  alu_result in   DATA_WIDTH          from alu out_alu
//  alu_cout   in   1                   from alu cout
//  rsp_valid  out  1                   response valid, held until rsp_ready
//  rsp_ready  in   1                   response consumer ready
//  rsp_id     out  $clog2(NUM_REQ)     index of the requester that issued the op
//  rsp_data   out  DATA_WIDTH          captured alu_result
//  rsp_cout   out  1                   captured alu_cout
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE.
//    All outputs are 0: req_ready, alu_a, alu_b, alu_mode, rsp_valid, rsp_id, rsp_data and rsp_cout.
//    The RR pointer last_grant is set to NUM_REQ-1, so requester 0 wins first. The wait counter is set to 0.
//  - Reset mid-operation: the in-flight op and any pending response are dropped with no response. Requesters must re-request.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//  - IDLE: req_ready is combinational and one-hot for the winner only.
//    The winner is the first i with req_valid[i]=1, scanning from last_grant+1 modulo NUM_REQ.
//    If no requester is valid, req_ready=0 and the FSM stays in IDLE.
//    On the accept edge:
//    - alu_a, alu_b and alu_mode are loaded from the winner's fields.
//    - rsp_id and last_grant are set to the winner.
//    - cnt is loaded with ALU_LATENCY and the FSM goes to WAIT.
//  - WAIT: req_ready=0 and alu_* are held stable.
//    If cnt==0, capture alu_result/alu_cout into rsp_data/rsp_cout and go to RESP. Otherwise decrement cnt.
//  - RESP: rsp_valid=1 and rsp_id/rsp_data/rsp_cout are stable.
//    On an edge with rsp_ready=1, rsp_valid goes to 0 and the FSM returns to IDLE.
//  - Latency: rsp_valid rises ALU_LATENCY+1 edges after the accept edge.
//    Best-case issue interval is ALU_LATENCY+3 cycles.
//  - req_valid may drop while not granted; a dropped request is not remembered.
//  - Simultaneous requests resolve by the RR scan. A requester granted last is lowest priority next.
//  - Width rules: data passes through unchanged, with no truncation or extension. rsp_cout is a 1-bit pass-through.
// CONFIGURATION
//  - ALU_ARB_FIXED_PRIO_EN defined: strict fixed priority, lowest index wins. last_grant is not used for selection.
//  - ALU_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.
// TESTING
//  1. Reset mid-WAIT: req0 accepted, reset_n=0 one cycle later.
//     -> All outputs are 0 immediately. No rsp_valid. The next single req2 is accepted with rsp_id=2.
//  2. Single op: req1 valid, a=8'h3C, b=8'h05, mode=4'd3.
//     -> req_ready=4'b0010 in the same cycle. Next cycle alu_a=8'h3C, alu_b=8'h05, alu_mode=3.
//     -> rsp_valid after 2 edges with rsp_id=1 and rsp_data equal to the alu model.
//  3. Round-robin: all four req_valid held high, rsp_ready=1.
//     -> Grant order 0,1,2,3,0,1, each grant 4 cycles apart (ALU_LATENCY=1).
//  4. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
//     -> rsp_* held stable, req_ready stays 0 for other requesters. Release -> IDLE on the next edge.
//  5. Fixed priority: build with ALU_ARB_FIXED_PRIO_EN and req0+req3 held high.
//     -> req0 is granted every time. Drop req0 -> req3 is granted.
//  6. Sweep: ALU_LATENCY=0 and 3 with random ops, mode 0..15.
//     -> rsp_data/rsp_cout match the alu model. Accept-to-valid is 1 and 4 edges respectively.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Purpose: shares one registered ALU between NUM_REQ requesters; round-robin grant, or strict lowest-index-first when ALU_ARB_FIXED_PRIO_EN is defined.
// Latency: rsp_valid rises ALU_LATENCY+1 edges after the accept edge; one op in flight, best-case issue interval ALU_LATENCY+3 cycles.
// Backpressure: the response is held until rsp_ready; no request is accepted while an op or its response is outstanding.
module alu_req_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 1,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]         req_mode,
  output logic [DATA_WIDTH-1:0]        alu_a,
  output logic [DATA_WIDTH-1:0]        alu_b,
  output logic [3:0]                   alu_mode,
  input  logic [DATA_WIDTH-1:0]        alu_result,
  input  logic                         alu_cout,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic                         rsp_cout
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t                  state;
  logic [ID_W-1:0]         last_grant;
  logic [2:0]              cnt;
  logic                    win_vld;
  logic [ID_W-1:0]         win_idx;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   win_a;
  logic [DATA_WIDTH-1:0]   win_b;
  logic [3:0]              win_mode;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Winner is the lowest-index valid requester; last_grant plays no part
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_vld = 1'b1;
        win_idx = ID_W'(i);
      end
    end
  end
`else
  int scan_idx;

  // Winner is the first valid requester scanning upward from last_grant+1, wrapping
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(last_grant) + k) % NUM_REQ;
      if (!win_vld && req_valid[ID_W'(scan_idx)]) begin
        win_vld = 1'b1;
        win_idx = ID_W'(scan_idx);
      end
    end
  end
`endif

  // Pull the winner's operands out of the packed request buses
  always_comb begin
    win_a    = '0;
    win_b    = '0;
    win_mode = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        win_a    = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        win_b    = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        win_mode = req_mode[i*4 +: 4];
      end
    end
  end

  // One-hot ready to the winner, only while idle and out of reset
  always_comb begin
    accept    = reset_n && (state == IDLE) && win_vld;
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  // Issue / wait-for-ALU / hold-response sequencer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_mode   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            alu_a      <= win_a;
            alu_b      <= win_b;
            alu_mode   <= win_mode;
            rsp_id     <= win_idx;
            last_grant <= win_idx;
            cnt        <= 3'(ALU_LATENCY);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            rsp_data  <= alu_result;
            rsp_cout  <= alu_cout;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: one DUT at ALU_LATENCY=1 for the main scenarios,
// plus DUTs at latency 0 and 3 sharing a stimulus stream for the opcode sweep.
module tb_alu_req_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // ALU_LATENCY=1 instance
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*DW-1:0] req_a, req_b;
  logic [NR*4-1:0]  req_mode;
  logic [DW-1:0]    alu_a, alu_b, alu_result, rsp_data;
  logic [3:0]       alu_mode;
  logic             alu_cout, rsp_valid, rsp_ready, rsp_cout;
  logic [IW-1:0]    rsp_id;

  // Sweep stimulus shared by the latency-0 (z_) and latency-3 (t_) instances
  logic [NR-1:0]    s_req_valid;
  logic [NR*DW-1:0] s_req_a, s_req_b;
  logic [NR*4-1:0]  s_req_mode;
  logic             s_rsp_ready;
  logic [NR-1:0]    z_req_ready, t_req_ready;
  logic [DW-1:0]    z_alu_a, z_alu_b, z_alu_result, z_rsp_data;
  logic [DW-1:0]    t_alu_a, t_alu_b, t_alu_result, t_rsp_data;
  logic [3:0]       z_alu_mode, t_alu_mode;
  logic             z_alu_cout, z_rsp_valid, z_rsp_cout;
  logic             t_alu_cout, t_rsp_valid, t_rsp_cout;
  logic [IW-1:0]    z_rsp_id, t_rsp_id;

  alu_req_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ALU_LATENCY(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout));

  alu_req_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ALU_LATENCY(0)) u_l0 (
    .clk(clk), .reset_n(reset_n), .req_valid(s_req_valid), .req_ready(z_req_ready),
    .req_a(s_req_a), .req_b(s_req_b), .req_mode(s_req_mode),
    .alu_a(z_alu_a), .alu_b(z_alu_b), .alu_mode(z_alu_mode),
    .alu_result(z_alu_result), .alu_cout(z_alu_cout),
    .rsp_valid(z_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(z_rsp_id),
    .rsp_data(z_rsp_data), .rsp_cout(z_rsp_cout));

  alu_req_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ALU_LATENCY(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .req_valid(s_req_valid), .req_ready(t_req_ready),
    .req_a(s_req_a), .req_b(s_req_b), .req_mode(s_req_mode),
    .alu_a(t_alu_a), .alu_b(t_alu_b), .alu_mode(t_alu_mode),
    .alu_result(t_alu_result), .alu_cout(t_alu_cout),
    .rsp_valid(t_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(t_rsp_id),
    .rsp_data(t_rsp_data), .rsp_cout(t_rsp_cout));

  // Reference ALU: returns {cout, result}
  function automatic logic [DW:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [3:0] m);
    logic [DW:0] r;
    case (m)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {1'b0, a} - {1'b0, b};
      4'd2:    r = {1'b0, a & b};
      4'd3:    r = {1'b0, a | b};
      4'd4:    r = {1'b0, a ^ b};
      4'd5:    r = {1'b0, ~a};
      4'd6:    r = {a, 1'b0};
      4'd7:    r = {a[0], 1'b0, a[DW-1:1]};
      4'd8:    r = {1'b0, a} + 9'd1;
      4'd9:    r = {1'b0, a} - 9'd1;
      4'd10:   r = {1'b0, b};
      4'd11:   r = {1'b0, ~(a & b)};
      4'd12:   r = {1'b0, ~(a | b)};
      4'd13:   r = {1'b0, ~(a ^ b)};
      4'd14:   r = {1'b0, DW'(a == b)};
      default: r = {1'b0, DW'(a < b)};
    endcase
    return r;
  endfunction

  // ALU models at latency 1, 0 and 3
  logic [DW:0] m1_q, t_p1, t_p2, t_p3;
  always_ff @(posedge clk) m1_q <= alu_fn(alu_a, alu_b, alu_mode);
  assign {alu_cout, alu_result} = m1_q;
  assign {z_alu_cout, z_alu_result} = alu_fn(z_alu_a, z_alu_b, z_alu_mode);
  always_ff @(posedge clk) begin
    t_p1 <= alu_fn(t_alu_a, t_alu_b, t_alu_mode);
    t_p2 <= t_p1;
    t_p3 <= t_p2;
  end
  assign {t_alu_cout, t_alu_result} = t_p3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r;
    r = 99;
    if ($countones(v) == 1)
      for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  int g_idx[8];
  int g_cyc[8];
  int g_n;

  // Record every grant on the main instance over ncyc cycles
  task automatic collect(input int ncyc);
    g_n = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (req_ready != '0 && g_n < 8) begin
        g_idx[g_n] = onehot_idx(req_ready);
        g_cyc[g_n] = c;
        g_n++;
      end
      tick();
    end
  endtask

  // Edges until rsp_valid on the main instance, 0 if it never came
  task automatic wait_rsp(output int edges);
    edges = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (rsp_valid) begin
        edges = e;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          edges, j, e0, e3;
    logic [DW-1:0] a, b;
    logic [DW:0]   exp;
    int          rr_exp[6];
    rr_exp = '{0, 1, 2, 3, 0, 1};

    reset_n     = 1'b0;
    req_valid   = 4'b1111;
    req_a       = '0;
    req_b       = '0;
    req_mode    = '0;
    rsp_ready   = 1'b0;
    s_req_valid = '0;
    s_req_a     = '0;
    s_req_b     = '0;
    s_req_mode  = '0;
    s_rsp_ready = 1'b0;
    tick();
    tick();

    // Reset state, even with requests pending
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_alu_a",     alu_a,     8'h00);
    check("rst_alu_b",     alu_b,     8'h00);
    check("rst_alu_mode",  alu_mode,  4'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id",    rsp_id,    2'd0);
    check("rst_rsp_data",  rsp_data,  8'h00);
    check("rst_rsp_cout",  rsp_cout,  1'b0);
    req_valid = '0;
    reset_n   = 1'b1;
    tick();

    // Reset during WAIT drops the op; then a lone req2 is served
    req_a[0 +: 8]  = 8'h11;
    req_b[0 +: 8]  = 8'h22;
    req_mode[0 +: 4] = 4'd0;
    req_valid = 4'b0001;
    #1;
    check("t1_ready0", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check("t1_alu_a", alu_a, 8'h11);
    reset_n = 1'b0;
    #1;
    check("t1_rst_alu_a", alu_a, 8'h00);
    check("t1_rst_alu_b", alu_b, 8'h00);
    check("t1_rst_valid", rsp_valid, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("t1_no_rsp", rsp_valid, 1'b0);
    req_a[16 +: 8]   = 8'h40;
    req_b[16 +: 8]   = 8'h07;
    req_mode[8 +: 4] = 4'd1;
    req_valid = 4'b0100;
    #1;
    check("t1_ready2", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    wait_rsp(edges);
    check("t1_latency", edges, 2);
    check("t1_rsp_id",   rsp_id,   2'd2);
    check("t1_rsp_data", rsp_data, 8'h39);
    check("t1_rsp_cout", rsp_cout, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t1_rsp_drop", rsp_valid, 1'b0);

    // Single op from req1 (OR), last grant was 2 so 1 wins the scan 3,0,1
    req_a[8 +: 8]    = 8'h3C;
    req_b[8 +: 8]    = 8'h05;
    req_mode[4 +: 4] = 4'd3;
    req_valid = 4'b0010;
    #1;
    check("t2_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    check("t2_alu_a",    alu_a,    8'h3C);
    check("t2_alu_b",    alu_b,    8'h05);
    check("t2_alu_mode", alu_mode, 4'd3);
    check("t2_valid_e0", rsp_valid, 1'b0);
    tick();
    check("t2_valid_e1", rsp_valid, 1'b0);
    tick();
    check("t2_valid_e2", rsp_valid, 1'b1);
    check("t2_rsp_id",   rsp_id,    2'd1);
    check("t2_rsp_data", rsp_data,  8'h3D);
    check("t2_rsp_cout", rsp_cout,  1'b0);

    // Backpressure: response held, nobody else granted
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      check("t4_ready_held", req_ready, 4'b0000);
      check("t4_rsp_held", {rsp_valid, rsp_id, rsp_cout, rsp_data}, {1'b1, 2'd1, 1'b0, 8'h3D});
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    check("t4_released", rsp_valid, 1'b0);
    req_valid = 4'b1000;
    #1;
    check("t4_idle_again", req_ready, 4'b1000);
    req_valid = '0;

    // Round-robin from reset with everyone requesting
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    req_valid = 4'b1111;
    #1;
    collect(24);
    req_valid = '0;
    check("t3_grant_count", g_n, 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t3_grant%0d", k), g_idx[k], rr_exp[k]);
      if (k > 0) check($sformatf("t3_gap%0d", k), g_cyc[k] - g_cyc[k-1], 4);
    end

    // req0 + req3 contending (last grant 1), then req3 alone
    req_valid = 4'b1001;
    #1;
    collect(12);
    check("t5_grant_count", g_n, 3);
`ifdef ALU_ARB_FIXED_PRIO_EN
    check("t5_grant0", g_idx[0], 0);
    check("t5_grant1", g_idx[1], 0);
    check("t5_grant2", g_idx[2], 0);
`else
    check("t5_grant0", g_idx[0], 3);
    check("t5_grant1", g_idx[1], 0);
    check("t5_grant2", g_idx[2], 3);
`endif
    req_valid = 4'b1000;
    #1;
    collect(4);
    req_valid = '0;
    check("t5_solo_count", g_n, 1);
    check("t5_solo_grant", g_idx[0], 3);
    rsp_ready = 1'b0;

    // Opcode sweep at latency 0 and 3
    for (int i = 0; i < 16; i++) begin
      j = int'($urandom_range(0, 3));
      a = 8'($urandom);
      b = 8'($urandom);
      s_req_a    = $urandom;
      s_req_b    = $urandom;
      s_req_mode = 16'($urandom);
      s_req_a[j*8 +: 8]    = a;
      s_req_b[j*8 +: 8]    = b;
      s_req_mode[j*4 +: 4] = 4'(i);
      exp = alu_fn(a, b, 4'(i));
      s_req_valid = '0;
      s_req_valid[j] = 1'b1;
      #1;
      check("sw_ready_l0", z_req_ready, s_req_valid);
      check("sw_ready_l3", t_req_ready, s_req_valid);
      tick();
      s_req_valid = '0;
      e0 = 0;
      e3 = 0;
      for (int e = 1; e <= 7; e++) begin
        tick();
        if (z_rsp_valid && e0 == 0) e0 = e;
        if (t_rsp_valid && e3 == 0) e3 = e;
      end
      check($sformatf("sw%0d_lat_l0", i),  e0, 1);
      check($sformatf("sw%0d_lat_l3", i),  e3, 4);
      check($sformatf("sw%0d_data_l0", i), z_rsp_data, exp[DW-1:0]);
      check($sformatf("sw%0d_cout_l0", i), z_rsp_cout, exp[DW]);
      check($sformatf("sw%0d_data_l3", i), t_rsp_data, exp[DW-1:0]);
      check($sformatf("sw%0d_cout_l3", i), t_rsp_cout, exp[DW]);
      check($sformatf("sw%0d_id_l0", i),   z_rsp_id,   j);
      check($sformatf("sw%0d_id_l3", i),   t_rsp_id,   j);
      s_rsp_ready = 1'b1;
      tick();
      s_rsp_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
